// File: rtl/pipelined_array_multiplier.sv
// pipelined_array_multiplier
//
// Pipelined WIDTH x WIDTH array multiplier with a per-transaction signed/unsigned mode
// and a full 2*WIDTH-bit product. Partial-product rows are split across
// STAGES = WIDTH / ROWS_PER_STAGE register stages. Every stage advances together under a
// single global stall, so backpressure on the output freezes the whole pipe.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; clears every stage and beats any handshake
//   in_valid     operand pair offered
//   in_ready     pair accepted this cycle (= !out_valid || out_ready)
//   in_a, in_b   multiplicand / multiplier, WIDTH bits
//   in_signed    1: both operands two's complement, 0: both unsigned
//   out_valid    out_product holds a result
//   out_ready    downstream consumes the result this cycle
//   out_product  2*WIDTH-bit product
//   busy         any stage holds a valid transaction

module pipelined_array_multiplier #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int unsigned STAGES = WIDTH / ROWS_PER_STAGE;
    localparam int unsigned PW     = 2 * WIDTH;

    if (WIDTH < 2 || ROWS_PER_STAGE == 0 || (WIDTH % ROWS_PER_STAGE) != 0) begin : g_bad_params
        $error("WIDTH must be >= 2 and an integer multiple of ROWS_PER_STAGE");
    end

    // Row i of the array: a (sign- or zero-extended to PW bits) gated by b[i], shifted by i.
    function automatic logic [PW-1:0] row_term(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn,
                                               input int unsigned      i);
        logic [PW-1:0]    ext;
        logic [WIDTH-1:0] b_sh;
        b_sh = b >> i;
        ext  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        if (!b_sh[0]) begin
            ext = '0;
        end
        return ext << i;
    endfunction

    logic              advance;
    logic [STAGES-1:0] valid_vec;

    // Global stall: the pipe moves only when the head result is absent or being consumed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign busy     = |valid_vec;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Base = k * ROWS_PER_STAGE;

        logic             v_src;
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic             sgn_src;
        logic [PW-1:0]    psum_src;
        logic [PW-1:0]    psum_d;
        logic             valid_q;
        logic [PW-1:0]    psum_q;

        if (k == 0) begin : g_first
            assign v_src    = in_valid;
            assign a_src    = in_a;
            assign b_src    = in_b;
            assign sgn_src  = in_signed;
            assign psum_src = '0;
        end else begin : g_rest
            assign v_src    = g_stage[k-1].valid_q;
            assign a_src    = g_stage[k-1].g_ops.a_q;
            assign b_src    = g_stage[k-1].g_ops.b_q;
            assign sgn_src  = g_stage[k-1].g_ops.sgn_q;
            assign psum_src = g_stage[k-1].psum_q;
        end

        // In signed mode the MSB row of b carries weight -2^(WIDTH-1), so it is subtracted.
        always_comb begin
            psum_d = psum_src;
            for (int unsigned r = 0; r < ROWS_PER_STAGE; r++) begin
                if (sgn_src && (Base + r == WIDTH - 1)) begin
                    psum_d = psum_d - row_term(a_src, b_src, sgn_src, Base + r);
                end else begin
                    psum_d = psum_d + row_term(a_src, b_src, sgn_src, Base + r);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                psum_q  <= '0;
            end else if (advance) begin
                valid_q <= v_src;
                psum_q  <= psum_d;
            end
        end

        // Operands travel with the partial sum; the final stage has no consumer for them.
        if (k < STAGES - 1) begin : g_ops
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             sgn_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sgn_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_src;
                    b_q   <= b_src;
                    sgn_q <= sgn_src;
                end
            end
        end

        assign valid_vec[k] = valid_q;
    end

    assign out_valid   = g_stage[STAGES-1].valid_q;
    assign out_product = g_stage[STAGES-1].psum_q;

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Scoreboard bench for pipelined_array_multiplier. Four instances cover the default
// configuration and the (4,1), (8,8) and (16,4) parameter points. The driver pushes the
// expected product on every accepted pair; a negedge monitor pops and compares whenever an
// instance hands a result downstream, and also checks in_ready and stall stability.

module tb_pipelined_array_multiplier;

    localparam int NI = 4;

    typedef struct packed {
        logic [31:0] prod;
        logic [31:0] cyc;
        logic        lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [NI];
    logic        in_signed [NI];
    logic        out_ready [NI];
    logic [15:0] in_a      [NI];
    logic [15:0] in_b      [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic        busy      [NI];
    logic [31:0] prod      [NI];
    logic [15:0] p0;
    logic [7:0]  p1;
    logic [15:0] p2;
    logic [31:0] p3;

    exp_t        sb [NI][$];
    bit          rand_rdy [NI];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        phold [NI];
    logic [31:0] pprod [NI];
    logic        prst;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int i);
        case (i)
            0: return 8;
            1: return 4;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int stg_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
        longint sa, sbv, p;
        sa  = longint'({48'b0, a});
        sbv = longint'({48'b0, b});
        if (s && ((a >> (w - 1)) & 16'd1) != 0) sa  = sa  - (longint'(1) << w);
        if (s && ((b >> (w - 1)) & 16'd1) != 0) sbv = sbv - (longint'(1) << w);
        p = sa * sbv;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    pipelined_array_multiplier #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]), .in_signed(in_signed[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_product(p0), .busy(busy[0])
    );
    pipelined_array_multiplier #(.WIDTH(4), .ROWS_PER_STAGE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][3:0]), .in_b(in_b[1][3:0]), .in_signed(in_signed[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_product(p1), .busy(busy[1])
    );
    pipelined_array_multiplier #(.WIDTH(8), .ROWS_PER_STAGE(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2][7:0]), .in_b(in_b[2][7:0]), .in_signed(in_signed[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_product(p2), .busy(busy[2])
    );
    pipelined_array_multiplier #(.WIDTH(16), .ROWS_PER_STAGE(4)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_a(in_a[3]), .in_b(in_b[3]), .in_signed(in_signed[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_product(p3), .busy(busy[3])
    );

    assign prod[0] = {16'b0, p0};
    assign prod[1] = {24'b0, p1};
    assign prod[2] = {16'b0, p2};
    assign prod[3] = p3;

    // Monitor: handshake rule, stall stability, and in-order result checking.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < NI; i++) begin
                chk("in_ready_rule", {31'b0, in_ready[i]}, {31'b0, !out_valid[i] || out_ready[i]});
                if (phold[i] && !prst) begin
                    chk("stall_hold_product", prod[i], pprod[i]);
                    chk("stall_hold_valid", {31'b0, out_valid[i]}, 32'd1);
                end
                if (out_valid[i] && out_ready[i] && !rst) begin
                    if (sb[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: inst %0d got %h expected none", i, prod[i]);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        chk($sformatf("product_inst%0d", i), prod[i], e.prod);
                        if (e.lat) chk($sformatf("latency_inst%0d", i), cyc - e.cyc, stg_of(i));
                    end
                end
                phold[i] = out_valid[i] && !out_ready[i];
                pprod[i] = prod[i];
            end
            prst = rst;
        end
    end

    // Downstream readiness: random while streaming, otherwise always ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                out_ready[i] = rand_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [31:0] exp, input bit lat);
        int n;
        n = 0;
        in_valid[i]  = 1'b1;
        in_a[i]      = a;
        in_b[i]      = b;
        in_signed[i] = s;
        forever begin
            @(negedge clk);
            if (in_ready[i] && !rst) begin
                sb[i].push_back('{prod: exp, cyc: cyc, lat: lat});
                break;
            end
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: inst %0d got no in_ready expected accept", i);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("drain_inst%0d_left", i), sb[i].size(), 0);
    endtask

    task automatic stream(input int i);
        logic [15:0] a, b, m;
        logic        s;
        m = 16'((32'd1 << w_of(i)) - 1);
        rand_rdy[i] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            a = 16'($urandom) & m;
            b = 16'($urandom) & m;
            s = 1'($urandom_range(0, 1));
            send(i, a, b, s, model(w_of(i), a, b, s), 1'b0);
        end
        drain(i);
        rand_rdy[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        prst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b1;
            in_a[i]      = 16'h0003;
            in_b[i]      = 16'h0005;
            in_signed[i] = 1'b0;
            out_ready[i] = 1'b1;
            rand_rdy[i]  = 1'b0;
            phold[i]     = 1'b0;
            pprod[i]     = '0;
        end

        // Reset held two cycles with pairs offered; none of them may ever emerge.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) in_valid[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_out_valid", {31'b0, out_valid[i]}, 32'd0);
            chk("reset_out_product", prod[i], 32'd0);
            chk("reset_busy", {31'b0, busy[i]}, 32'd0);
            chk("reset_in_ready", {31'b0, in_ready[i]}, 32'd1);
        end
        repeat (8) @(posedge clk);
        #1;

        // Unsigned corners, back-to-back.
        send(0, 16'd255, 16'd255, 1'b0, 32'h0000_FE01, 1'b1);
        send(0, 16'd0,   16'd200, 1'b0, 32'h0000_0000, 1'b1);
        send(0, 16'd1,   16'd173, 1'b0, 32'h0000_00AD, 1'b1);
        drain(0);

        // Signed corners interleaved with an unsigned 128*128.
        send(0, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000, 1'b1);
        send(0, 16'h0080, 16'h0080, 1'b0, 32'h0000_4000, 1'b1);
        send(0, 16'h0080, 16'h007F, 1'b1, 32'h0000_C080, 1'b1);
        send(0, 16'h00FF, 16'h0001, 1'b1, 32'h0000_FFFF, 1'b1);
        drain(0);

        stream(0);

        // Mid-operation reset one cycle before the first result is due.
        send(0, 16'd10, 16'd20, 1'b0, 32'd200, 1'b0);
        send(0, 16'd7,  16'd9,  1'b0, 32'd63,  1'b0);
        send(0, 16'd2,  16'd2,  1'b0, 32'd4,   1'b0);
        rst = 1'b1;
        for (int i = 0; i < NI; i++) sb[i].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("midreset_no_result", {31'b0, out_valid[0]}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(0, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b1);
        drain(0);

        // Parameter sweep: latency, a signed corner, then a random stream.
        send(1, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b1);
        send(1, 16'h0008, 16'h0008, 1'b1, 32'h0000_0040, 1'b1);
        drain(1);
        stream(1);
        send(2, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b1);
        send(2, 16'h0080, 16'h007F, 1'b1, 32'h0000_C080, 1'b1);
        drain(2);
        stream(2);
        send(3, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b1);
        send(3, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1);
        send(3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1);
        drain(3);
        stream(3);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
